// File: rtl/rx_dma_arbiter.sv
// rx_dma_arbiter: frame-granular round-robin sharing of the bus-master command
// FIFO between the two PHY RX AFIFO read ports. Each granted frame gets a
// two-word host address header. One host ring write pointer is kept per port.
module rx_dma_arbiter #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned LEN_W     = 20
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [17:0]      phy1_dout,
  input  logic             phy1_empty,
  output logic             phy1_rd_en,
  input  logic [17:0]      phy2_dout,
  input  logic             phy2_empty,
  output logic             phy2_rd_en,
  output logic [17:0]      mst_din,
  output logic             mst_wr_en,
  input  logic             mst_full,
  input  logic [1:0]       dma_enable,
  input  logic [LEN_W-1:0] dma_length,
  input  logic [29:0]      dma1_addr_start,
  input  logic [29:0]      dma2_addr_start,
  output logic [29:0]      dma1_addr_cur,
  output logic [29:0]      dma2_addr_cur,
  output logic [1:0]       grant,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_XFER, S_DROP, S_UPDATE
  } state_t;

  localparam logic [10:0] LAST_IDX = 11'(MAX_WORDS - 1);

  state_t      state, state_nxt;
  logic        port;        // 0 = port1, 1 = port2
  logic        last_port;   // port that completed the most recent frame
  logic [29:0] cur_lat;
  logic [10:0] wcnt;
  logic        ovf;
  logic        pend;        // a read was issued last cycle, word on dout now
  logic        skid_vld;
  logic [17:0] skid;
  logic [1:0]  en_q;

  logic        req1, req2, pick2;
  logic [17:0] sel_dout;
  logic        sel_empty;
  logic        src_vld, src_eof;
  logic [17:0] src;
  logic        last_word, consume, rd_go, fetch_state;
  logic [11:0] wsum;
  logic [29:0] adv, nxt_addr, sel_start, limit;
  logic        wrap;
  logic        unused_bits;

  assign unused_bits = ^{phy1_dout[16], phy2_dout[16], src[16]};

  assign req1      = !phy1_empty;
  assign req2      = !phy2_empty;
  assign pick2     = req2 && (!req1 || !last_port);
  assign sel_dout  = port ? phy2_dout : phy1_dout;
  assign sel_empty = port ? phy2_empty : phy1_empty;
  // The skid holds the oldest word; a word on dout is only used when the skid is empty.
  assign src_vld   = skid_vld || pend;
  assign src       = skid_vld ? skid : sel_dout;
  assign src_eof   = src[17];
  assign last_word = (wcnt == LAST_IDX);

  assign wsum      = {1'b0, wcnt} + 12'd1;
  assign adv       = {19'd0, wsum[11:1]};
  assign nxt_addr  = cur_lat + adv;
  assign sel_start = port ? dma2_addr_start : dma1_addr_start;
  assign limit     = sel_start + 30'(dma_length);
  assign wrap      = (nxt_addr >= limit);

  assign fetch_state = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                       (state == S_XFER)   || (state == S_DROP);
  // Reading stops once the EOF word is in hand so the next frame is never touched;
  // a new read is allowed only if the skid will be empty when its word arrives.
  assign rd_go      = fetch_state && !sel_empty &&
                      (!src_vld || (consume && !src_eof));
  assign phy1_rd_en = rd_go && !port;
  assign phy2_rd_en = rd_go && port;

  // Next-state, master FIFO write and word-consume decode.
  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    mst_wr_en = 1'b0;
    mst_din   = '0;
    case (state)
      S_IDLE: begin
        if (req1 || req2)
          state_nxt = dma_enable[pick2] ? S_HDR_HI : S_DROP;
      end
      S_HDR_HI: begin
        if (!mst_full) begin
          mst_wr_en = 1'b1;
          mst_din   = {2'b10, cur_lat[29:14]};
          state_nxt = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (!mst_full) begin
          mst_wr_en = 1'b1;
          mst_din   = {2'b11, cur_lat[13:0], 2'b00};
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (src_vld && !mst_full) begin
          consume   = 1'b1;
          mst_wr_en = 1'b1;
          mst_din   = {1'b0, src_eof || last_word, src[15:0]};
          if (src_eof)
            state_nxt = S_UPDATE;
          else if (last_word)
            state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (src_vld) begin
          consume = 1'b1;
          if (src_eof)
            state_nxt = S_IDLE;
        end
      end
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Grant, per-frame context, word counter and drop statistics.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      port      <= 1'b0;
      grant     <= '0;
      last_port <= 1'b1;
      cur_lat   <= '0;
      wcnt      <= '0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req1 || req2) begin
            port    <= pick2;
            grant   <= pick2 ? 2'b10 : 2'b01;
            cur_lat <= pick2 ? dma2_addr_cur : dma1_addr_cur;
            wcnt    <= '0;
            ovf     <= 1'b0;
          end
        end
        S_XFER: begin
          if (consume) begin
            wcnt <= wcnt + 11'd1;
            if (!src_eof && last_word)
              ovf <= 1'b1;
          end
        end
        S_DROP: begin
          if (consume && src_eof) begin
            grant <= '0;
            if (!ovf && (drop_cnt != '1))
              drop_cnt <= drop_cnt + 16'd1;
          end
        end
        S_UPDATE: begin
          last_port <= port;
          grant     <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read-latency tracking and one-entry skid for words blocked by mst_full.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend     <= 1'b0;
      skid_vld <= 1'b0;
      skid     <= '0;
    end else begin
      pend     <= rd_go;
      skid_vld <= src_vld && !consume;
      if (pend && !skid_vld && !consume)
        skid <= sel_dout;
    end
  end

  // Ring write pointers: reload on enable rising edge, else advance after a frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_q          <= '0;
      dma1_addr_cur <= '0;
      dma2_addr_cur <= '0;
    end else begin
      en_q <= dma_enable;
      if (dma_enable[0] && !en_q[0])
        dma1_addr_cur <= dma1_addr_start;
      else if (state == S_UPDATE && !port)
        dma1_addr_cur <= wrap ? dma1_addr_start : nxt_addr;
      if (dma_enable[1] && !en_q[1])
        dma2_addr_cur <= dma2_addr_start;
      else if (state == S_UPDATE && port)
        dma2_addr_cur <= wrap ? dma2_addr_start : nxt_addr;
    end
  end

endmodule

// File: tb/tb_rx_dma_arbiter.sv
// tb_rx_dma_arbiter: directed frames into two AFIFO models; a monitor pops an
// expected-write queue and an expected-grant queue whenever the DUT presents them.
module tb_rx_dma_arbiter;

  localparam int MAXW = 64;
  localparam logic [29:0] START1 = 30'h0100_0000;
  localparam logic [29:0] START2 = 30'h0200_0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [17:0] phy1_dout = '0, phy2_dout = '0;
  logic        phy1_empty = 1'b1, phy2_empty = 1'b1;
  logic        phy1_rd_en, phy2_rd_en;
  logic [17:0] mst_din;
  logic        mst_wr_en;
  logic        mst_full;
  logic [1:0]  dma_enable;
  logic [19:0] dma_length;
  logic [29:0] dma1_addr_start, dma2_addr_start;
  logic [29:0] dma1_addr_cur, dma2_addr_cur;
  logic [1:0]  grant;
  logic [15:0] drop_cnt;

  logic [17:0] q1[$];
  logic [17:0] q2[$];
  logic [17:0] sb[$];
  logic [1:0]  gq[$];
  int unsigned n_chk = 0, n_pass = 0, n_wr = 0, cyc = 0, wr0;
  logic        stall_en = 1'b0;
  logic [1:0]  grant_q = '0;

  always #4 sys_clk = ~sys_clk;

  rx_dma_arbiter #(.MAX_WORDS(MAXW), .LEN_W(20)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .phy1_dout(phy1_dout), .phy1_empty(phy1_empty), .phy1_rd_en(phy1_rd_en),
    .phy2_dout(phy2_dout), .phy2_empty(phy2_empty), .phy2_rd_en(phy2_rd_en),
    .mst_din(mst_din), .mst_wr_en(mst_wr_en), .mst_full(mst_full),
    .dma_enable(dma_enable), .dma_length(dma_length),
    .dma1_addr_start(dma1_addr_start), .dma2_addr_start(dma2_addr_start),
    .dma1_addr_cur(dma1_addr_cur), .dma2_addr_cur(dma2_addr_cur),
    .grant(grant), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // AFIFO models: dout valid the cycle after rd_en.
  always @(posedge sys_clk) begin
    if (phy1_rd_en) begin
      if (q1.size() == 0) begin n_chk++; $display("FAIL phy1_underrun: got rd_en expected none"); end
      else phy1_dout <= q1.pop_front();
    end
    if (phy2_rd_en) begin
      if (q2.size() == 0) begin n_chk++; $display("FAIL phy2_underrun: got rd_en expected none"); end
      else phy2_dout <= q2.pop_front();
    end
    phy1_empty <= (q1.size() == 0);
    phy2_empty <= (q2.size() == 0);
  end

  // Master FIFO back-pressure generator.
  initial begin
    mst_full = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      cyc++;
      mst_full = stall_en && (cyc % 3 == 0);
    end
  end

  // Monitor: compare each master write and each new grant against the scoreboards.
  always @(negedge sys_clk) begin
    if (mst_wr_en) begin
      n_wr++;
      if (sb.size() == 0) begin n_chk++; $display("FAIL mst_extra: got %h expected no write", mst_din); end
      else check("mst_din", {14'd0, mst_din}, {14'd0, sb.pop_front()});
    end
    if (grant != grant_q && grant != 2'b00) begin
      if (gq.size() == 0) begin n_chk++; $display("FAIL grant_extra: got %b expected none", grant); end
      else check("grant", {30'd0, grant}, {30'd0, gq.pop_front()});
    end
    grant_q = grant;
  end

  task automatic push_frame(input int p, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      d = base + 16'(i);
      if (p == 1) q1.push_back({i == n - 1, 1'b0, d});
      else        q2.push_back({i == n - 1, 1'b0, d});
    end
  endtask

  task automatic exp_hdr(input logic [15:0] hi, input logic [15:0] lo);
    sb.push_back({2'b10, hi});
    sb.push_back({2'b11, lo});
  endtask

  task automatic exp_data(input int n, input logic [15:0] base);
    int w;
    w = (n > MAXW) ? MAXW : n;
    for (int i = 0; i < w; i++) begin
      logic [15:0] d;
      d = base + 16'(i);
      sb.push_back({1'b0, i == w - 1, d});
    end
  endtask

  task automatic wait_idle(input string name);
    int unsigned k;
    k = 0;
    while (!(q1.size() == 0 && q2.size() == 0 && sb.size() == 0 && grant == 2'b00 &&
             phy1_empty && phy2_empty) && k < 4000) begin
      @(posedge sys_clk); #1;
      k++;
    end
    if (k >= 4000) begin
      n_chk++;
      $display("FAIL %s_timeout: got busy expected idle within 4000 cycles", name);
    end
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    dma_enable = 2'b00;
    dma_length = 20'h01000;
    dma1_addr_start = START1;
    dma2_addr_start = START2;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_wr_en", {31'd0, mst_wr_en}, 32'd0);
    check("rst_din", {14'd0, mst_din}, 32'd0);
    check("rst_rd_en", {30'd0, phy1_rd_en, phy2_rd_en}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);
    check("rst_cur1", {2'd0, dma1_addr_cur}, 32'd0);
    check("rst_cur2", {2'd0, dma2_addr_cur}, 32'd0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    dma_enable = 2'b11;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reload_cur1", {2'd0, dma1_addr_cur}, {2'd0, START1});
    check("reload_cur2", {2'd0, dma2_addr_cur}, {2'd0, START2});

    // 30-word frame on port1
    gq.push_back(2'b01);
    exp_hdr(16'h0400, 16'h0000);
    exp_data(30, 16'h1000);
    push_frame(1, 30, 16'h1000);
    wait_idle("t1");
    check("t1_cur1", {2'd0, dma1_addr_cur}, {2'd0, START1 + 30'd15});

    // Both ports loaded: port1 finished last, so port2 wins the first tie
    gq.push_back(2'b10); exp_hdr(16'h0800, 16'h0000); exp_data(4, 16'h2000);
    gq.push_back(2'b01); exp_hdr(16'h0400, 16'h003C); exp_data(4, 16'h3000);
    gq.push_back(2'b10); exp_hdr(16'h0800, 16'h0008); exp_data(4, 16'h2100);
    gq.push_back(2'b01); exp_hdr(16'h0400, 16'h0044); exp_data(4, 16'h3100);
    push_frame(1, 4, 16'h3000); push_frame(1, 4, 16'h3100);
    push_frame(2, 4, 16'h2000); push_frame(2, 4, 16'h2100);
    wait_idle("t2");
    check("t2_cur1", {2'd0, dma1_addr_cur}, {2'd0, START1 + 30'd19});
    check("t2_cur2", {2'd0, dma2_addr_cur}, {2'd0, START2 + 30'd4});

    // 64-word frame (exactly MAXW, EOF on last) under periodic mst_full
    wr0 = n_wr;
    stall_en = 1'b1;
    gq.push_back(2'b01);
    exp_hdr(16'h0400, 16'h004C);
    exp_data(64, 16'h4000);
    push_frame(1, 64, 16'h4000);
    wait_idle("t3");
    stall_en = 1'b0;
    check("t3_writes", n_wr - wr0, 32'd66);
    check("t3_cur1", {2'd0, dma1_addr_cur}, {2'd0, START1 + 30'd51});

    // Ring wrap with dma_length=16 on port2 after a pointer reload
    dma_enable = 2'b01;
    repeat (2) @(posedge sys_clk); #1;
    dma_enable = 2'b11;
    dma_length = 20'd16;
    repeat (2) @(posedge sys_clk); #1;
    gq.push_back(2'b10); exp_hdr(16'h0800, 16'h0000); exp_data(24, 16'h5000);
    push_frame(2, 24, 16'h5000);
    wait_idle("t4a");
    check("t4_cur2_a", {2'd0, dma2_addr_cur}, {2'd0, START2 + 30'd12});
    gq.push_back(2'b10); exp_hdr(16'h0800, 16'h0030); exp_data(10, 16'h5100);
    push_frame(2, 10, 16'h5100);
    wait_idle("t4b");
    check("t4_cur2_wrap", {2'd0, dma2_addr_cur}, {2'd0, START2});
    gq.push_back(2'b10); exp_hdr(16'h0800, 16'h0000); exp_data(2, 16'h5200);
    push_frame(2, 2, 16'h5200);
    wait_idle("t4c");
    check("t4_cur2_c", {2'd0, dma2_addr_cur}, {2'd0, START2 + 30'd1});
    dma_length = 20'h01000;

    // Disabled port2: frame dropped without any master writes
    dma_enable = 2'b01;
    wr0 = n_wr;
    gq.push_back(2'b10);
    push_frame(2, 7, 16'h6000);
    wait_idle("t5");
    check("t5_writes", n_wr - wr0, 32'd0);
    check("t5_drained", q2.size(), 32'd0);
    check("t5_drop", {16'd0, drop_cnt}, 32'd1);
    check("t5_cur2", {2'd0, dma2_addr_cur}, {2'd0, START2 + 30'd1});

    // Oversize 70-word frame: 64 written, last forced to tag 01, tail dropped
    gq.push_back(2'b01); exp_hdr(16'h0400, 16'h00CC); exp_data(70, 16'h7000);
    push_frame(1, 70, 16'h7000);
    wait_idle("t6a");
    check("t6_drop", {16'd0, drop_cnt}, 32'd1);
    check("t6_cur1", {2'd0, dma1_addr_cur}, {2'd0, START1 + 30'd51});
    gq.push_back(2'b01); exp_hdr(16'h0400, 16'h00CC); exp_data(3, 16'h7100);
    push_frame(1, 3, 16'h7100);
    wait_idle("t6b");
    check("t6_cur1_next", {2'd0, dma1_addr_cur}, {2'd0, START1 + 30'd53});

    // Zero ring length: update always wraps to start
    dma_length = 20'd0;
    gq.push_back(2'b01); exp_hdr(16'h0400, 16'h00D4); exp_data(2, 16'h8000);
    push_frame(1, 2, 16'h8000);
    wait_idle("t7");
    check("t7_cur1", {2'd0, dma1_addr_cur}, {2'd0, START1});

    check("sb_left", sb.size(), 32'd0);
    check("gq_left", gq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
